parallelin_serialout: RTL and testbench

Upstream stage for the serial-in/parallel-out shift register. It accepts a WIDTH-bit parallel word over a valid/ready handshake and serialises it one bit per clock onto d. d_valid and last give the downstream shifter exact frame boundaries. Words can stream back-to-back with no gap, or be separated by a fixed number of idle cycles.

---
 rtl/sr_pkg.sv | 17 +
 rtl/parallelin_serialout.sv | 106 ++++++++++
 tb/tb_parallelin_serialout.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the serial-out / serial-in shift register pair.
// Default parallel width and state encoding.
package sr_pkg;

  localparam int SR_WIDTH = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP
  } state_t;

endpackage

// File: rtl/parallelin_serialout.sv
// Parallel-in / serial-out stage: takes a word over valid/ready and
// streams it one bit per clock with frame valid and last markers.
module parallelin_serialout
  import sr_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH,
  parameter int LSB_FIRST = 0,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             d,
  output logic             d_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             load;
  logic             gap_done;
  logic             out_bit_n;

  assign din_ready = !rst && ((state == S_IDLE) ||
                     (GAP == 0 && state == S_SHIFT && cnt == CNT_LAST));
  assign load = din_valid && din_ready;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: begin
      end
      S_SHIFT: begin
        if (cnt == CNT_LAST) begin
          sreg_n  = '0;
          cnt_n   = '0;
          state_n = (GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          sreg_n = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
          cnt_n  = cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (gap_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // A reload on the last bit keeps frames back-to-back.
    if (load) begin
      sreg_n  = din;
      cnt_n   = '0;
      state_n = S_SHIFT;
    end
  end

  assign out_bit_n = (LSB_FIRST != 0) ? sreg_n[0] : sreg_n[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sreg    <= '0;
      cnt     <= '0;
      d       <= 1'b0;
      d_valid <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      cnt     <= cnt_n;
      d       <= (state_n == S_SHIFT) && out_bit_n;
      d_valid <= (state_n == S_SHIFT);
      last    <= (state_n == S_SHIFT) && (cnt_n == CNT_LAST);
      busy    <= (state_n != S_IDLE);
    end
  end

  if (GAP > 0) begin : g_gap
    localparam int GW = $clog2(GAP + 1);
    logic [GW-1:0] gcnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        gcnt <= '0;
      end else if (state == S_GAP) begin
        gcnt <= gcnt + GW'(1);
      end else begin
        gcnt <= '0;
      end
    end

    assign gap_done = (gcnt == GW'(GAP - 1));
  end else begin : g_nogap
    assign gap_done = 1'b1;
  end

endmodule

// File: tb/tb_parallelin_serialout.sv
// Bench for parallelin_serialout: three configurations driven in parallel,
// each with a frame-level reference model and a bit scoreboard.
module tb_parallelin_serialout;

  logic       clk;
  logic       rst;
  logic [7:0] din [3];
  logic       vld [3];
  logic       rdy [3];
  logic       dd  [3];
  logic       dv  [3];
  logic       lst [3];
  logic       bsy [3];

  logic [7:0] stim [3][$];
  int         pend [3];
  bit         go;
  bit         rand_mode;

  int n_cmp;
  int n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int k,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got=%0h want=%0h",
               nm, k, $time, act, exp);
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_inst
    localparam int W = (i == 2) ? 4 : 3;
    localparam int L = (i == 2) ? 1 : 0;
    localparam int G = (i == 1) ? 2 : ((i == 2) ? 1 : 0);

    parallelin_serialout #(
      .WIDTH(W),
      .LSB_FIRST(L),
      .GAP(G)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .din(din[i][W-1:0]),
      .din_valid(vld[i]),
      .din_ready(rdy[i]),
      .d(dd[i]),
      .d_valid(dv[i]),
      .last(lst[i]),
      .busy(bsy[i])
    );

    // Reference: bits left in the current frame and idle cycles owed.
    int rem;
    int grem;
    bit eq  [$];
    bit elq [$];
    bit taken;

    initial begin
      rem  = 0;
      grem = 0;
    end

    always @(negedge clk) begin
      logic exp_rdy;
      logic eb;
      logic el;
      if (rst) begin
        chk("rst_out", i, {3'b0, dd[i], dv[i], lst[i], bsy[i], rdy[i]}, 8'h0);
        eq.delete();
        elq.delete();
        rem  = 0;
        grem = 0;
      end else begin
        exp_rdy = (rem == 0 && grem == 0) || (G == 0 && rem == 1);
        chk("din_ready", i, {7'b0, rdy[i]}, {7'b0, exp_rdy});
        chk("d_valid", i, {7'b0, dv[i]}, {7'b0, rem > 0});
        chk("busy", i, {7'b0, bsy[i]}, {7'b0, (rem > 0) || (grem > 0)});
        if (dv[i]) begin
          if (eq.size() == 0) begin
            chk("underflow", i, 8'd1, 8'd0);
          end else begin
            eb = eq.pop_front();
            el = elq.pop_front();
            chk("d", i, {7'b0, dd[i]}, {7'b0, eb});
            chk("last", i, {7'b0, lst[i]}, {7'b0, el});
          end
        end else begin
          chk("idle_out", i, {6'b0, dd[i], lst[i]}, 8'h0);
        end
        if (rem > 0) begin
          rem--;
          if (rem == 0) grem = G;
        end else if (grem > 0) begin
          grem--;
        end
        if (vld[i] && exp_rdy) begin
          rem = W;
          for (int k = 0; k < W; k++) begin
            eq.push_back((L != 0) ? din[i][k] : din[i][W-1-k]);
            elq.push_back(k == W - 1);
          end
        end
      end
      pend[i] = eq.size();
    end

    initial begin
      taken = 1'b0;
      wait (go);
      forever begin
        @(negedge clk);
        taken = vld[i] && rdy[i] && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
          vld[i] = 1'b0;
        end else if (taken || !vld[i]) begin
          if (stim[i].size() > 0 &&
              !(rand_mode && $urandom_range(0, 9) < 3)) begin
            din[i] = stim[i].pop_front();
            vld[i] = 1'b1;
          end else begin
            vld[i] = 1'b0;
            din[i] = 8'($urandom);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk);
      #1;
      n++;
      done = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (stim[k].size() != 0 || vld[k] || bsy[k] || dv[k]) done = 1'b0;
      end
    end
    if (!done) chk("idle_timeout", 0, 8'd1, 8'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    n_cmp     = 0;
    n_fail    = 0;
    go        = 1'b0;
    rand_mode = 1'b0;
    rst       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = 8'hFF;
      vld[k] = 1'b1;
    end
    repeat (4) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) vld[k] = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    go = 1'b1;

    stim[0].push_back(8'b101);
    stim[1].push_back(8'b101);
    stim[2].push_back(8'b0100);
    wait_idle(100);

    stim[0].push_back(8'b110);
    stim[0].push_back(8'b011);
    stim[1].push_back(8'b110);
    stim[1].push_back(8'b011);
    stim[2].push_back(8'b0110);
    stim[2].push_back(8'b0011);
    wait_idle(100);

    stim[0].push_back(8'b111);
    stim[1].push_back(8'b111);
    stim[2].push_back(8'b1111);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dv[0] && n < 50);
    if (!dv[0]) chk("first_bit_timeout", 0, 8'd1, 8'd0);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) stim[k].delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    stim[0].push_back(8'b010);
    stim[1].push_back(8'b010);
    stim[2].push_back(8'b0010);
    wait_idle(100);

    rand_mode = 1'b1;
    for (int j = 0; j < 40; j++) begin
      stim[0].push_back(8'($urandom_range(0, 7)));
      stim[1].push_back(8'($urandom_range(0, 7)));
      stim[2].push_back(8'($urandom_range(0, 15)));
    end
    wait_idle(3000);

    for (int k = 0; k < 3; k++) chk("drain", k, 8'(pend[k]), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
